uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  8N1 UART receiver; the counterpart of uart_tx, and it shares its CLK_FREQ/BAUDRATE parameters.
//  Synchronises the asynchronous rx line, detects the start bit and validates it at mid-bit.
//  Samples 8 data bits LSB-first at bit centres, then checks the stop bit.
//  Presents each byte with a one-clock valid pulse; sits between the USB-UART pin and user logic.
// PARAMETERS
//  CLK_FREQ  50000000  system clock frequency in Hz
//  BAUDRATE  9600      line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUDRATE (integer divide, 5208 at defaults)
// PORTS
//  clk        in   1  system clock, all logic on its rising edge
//  reset_n    in   1  asynchronous, active-low reset
//  rx         in   1  serial input, asynchronous to clk, idles high
//  data       out  8  last correctly framed byte; held until the next good frame
//  valid      out  1  one-clock pulse: data was updated this cycle
//  frame_err  out  1  one-clock pulse: stop bit sampled low; data not updated
//  busy       out  1  high while a frame is in progress (state != IDLE)
// BEHAVIOUR
//  - Reset values: data=8'h00, valid=0, frame_err=0, busy=0, FSM=IDLE, counters=0; sync flops reset to 1.
//  - rx passes through a 2-flop synchroniser (rx_s); rx_d holds the previous rx_s.
//  - fall = rx_d & ~rx_s.
//  - The bit counter clk_cnt counts 0..CLKS_PER_BIT-1. HALF = CLKS_PER_BIT/2.
//  - IDLE: on fall go to START with clk_cnt=0. Otherwise stay in IDLE.
//  - START: when clk_cnt==HALF-1, sample rx_s.
//      - rx_s low: go to DATA with clk_cnt=0 and bit_idx=0.
//      - rx_s high: treat as a glitch and go back to IDLE; no pulse.
//  - DATA: when clk_cnt==CLKS_PER_BIT-1, shift rx_s into shreg[7] (right shift, LSB first) and clear clk_cnt.
//      - After bit_idx==7 go to STOP; otherwise bit_idx+1.
//  - STOP: when clk_cnt==CLKS_PER_BIT-1, sample rx_s.
//      - rx_s high: data<=shreg and valid=1 for that one cycle.
//      - rx_s low: frame_err=1 for one cycle; data is kept.
//      - Either way go to IDLE in the same cycle, at the stop-bit centre.
//  - Latency: valid is asserted HALF + 9*CLKS_PER_BIT clocks after the FSM leaves IDLE.
//  - Back-to-back frames:
//      - The FSM re-arms at the stop-bit centre, so a start edge half a bit later is caught.
//      - No idle gap is needed.
//  - Break or stuck-low line: fall needs rx_d high, so no new frame starts until rx returns high.
//      - One frame_err is reported per break.
//  - valid and frame_err are never high in the same cycle.
//  - busy is combinational from the state; it goes low in the cycle after the stop sample.
//  - Reset asserted mid-frame: abort immediately with no pulse; the partial byte is discarded.
//  - Counter widths: clk_cnt is $clog2(CLKS_PER_BIT) bits; bit_idx is 3 bits.
//  - Baud tolerance: centre sampling gives about ±4% total mismatch across a 10-bit frame.
// STRUCTURE
//  - uart_pkg.vh holds the shared constants:
//      - FSM state encodings IDLE/START/DATA/STOP (2-bit localparams);
//      - the CLKS_PER_BIT and HALF formulas;
//      - DATA_BITS=8.
//  - Include uart_pkg.vh from both uart_tx and uart_rx.
//  - One sub-module: sync_2ff. Generic 2-flop synchroniser with a RESET_VAL parameter.
//      - uart_rx uses RESET_VAL=1.
//      - The top level reuses it for the buttons.
//  - Everything else, FSM and counters, is flat in uart_rx.
// TESTING  (bench params: CLK_FREQ=1000000, BAUDRATE=100000, so CLKS_PER_BIT=10, HALF=5)
//  - Single frame 0x31: drive rx 0,1,0,0,0,1,1,0,0,1 at 10 clk/bit.
//      -> one valid pulse, data=8'h31, frame_err never high, busy low afterwards.
//  - Back-to-back 0x55 then 0xAA with no idle gap.
//      -> two valid pulses 100 clks apart, data 8'h55 then 8'hAA.
//  - Glitch: rx low for 3 clks, then high.
//      -> FSM returns to IDLE, busy high for no more than HALF+3 clks, no valid, no frame_err.
//  - Bad stop: frame 0xA5 with the stop bit held low, then release.
//      -> frame_err pulse, no valid, data keeps its previous value.
//      -> a following 0x3C is received correctly.
//  - Reset mid-frame: pull reset_n low at bit 4 of 0xF0, release, then send 0x0F.
//      -> all outputs 0 during reset; only 0x0F is reported.
//  - Loopback with uart_tx (same params): send 0x00, 0xFF and 0x31.
//      -> each byte received matches; also repeat with the rx bit period stretched 3% -> still correct.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: FSM encodings, frame width and baud divider helpers.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned BIT_IDX_W = 3;

    // Clocks per serial bit (integer divide).
    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                      input int unsigned baudrate);
        return clk_freq / baudrate;
    endfunction

    // Half a bit period, used to land on the start-bit centre.
    function automatic int unsigned calc_half(input int unsigned clk_freq,
                                              input int unsigned baudrate);
        return (clk_freq / baudrate) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops to settle metastability before use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit validation at mid-bit, centre sampling, stop check.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUDRATE = 9600
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUDRATE);
    localparam int unsigned HALF         = calc_half(CLK_FREQ, BAUDRATE);
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic                 rx_s;
    logic                 rx_d_q;
    logic                 fall;

    logic [1:0]           state_q,     state_d;
    logic [CNT_W-1:0]     clk_cnt_q,   clk_cnt_d;
    logic [BIT_IDX_W-1:0] bit_idx_q,   bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q,     shreg_d;
    logic [DATA_BITS-1:0] data_q,      data_d;
    logic                 valid_q,     valid_d;
    logic                 frame_err_q, frame_err_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign fall = rx_d_q & ~rx_s;

    // Frame FSM: next state, counters, shift register and output pulses.
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_cnt_d = '0;
                if (fall) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (clk_cnt_q == CNT_W'(HALF - 1)) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    // A start bit that is high again at its centre was a glitch.
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
                    shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
                    if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
                    state_d   = ST_IDLE;
                    if (rx_s) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clk_cnt_d = '0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_d_q      <= 1'b1;
            state_q     <= ST_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_d_q      <= rx_s;
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
